// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan-chain test controller.
// Holds the controller state encoding and the bit-counter width helper.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_DONE      = 3'd4
  } scan_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_popcount.sv
// Population count of a W-bit vector; used for the response error count.
// Purely combinational; the caller feeds it registered data only.
module scan_popcount #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  // Sum the set bits of the input vector.
  always_comb begin
    cnt_o = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain test controller: loads a pattern, pulses one capture cycle,
// unloads the response and compares it against an expected vector.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic                 S0,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 MISMATCH,
  output logic [CNT_W-1:0]     ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 done_q, done_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      pat_q   <= {CHAIN_LEN{1'b0}};
      exp_q   <= {CHAIN_LEN{1'b0}};
      resp_q  <= {CHAIN_LEN{1'b0}};
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; SE/SI/DONE are computed one edge ahead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    resp_d  = resp_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_SHIFT_IN;
          cnt_d   = {CNT_W{1'b0}};
          // pat_q keeps the not-yet-presented bits, MSB first.
          pat_d   = {PAT[CHAIN_LEN-2:0], 1'b0};
          exp_d   = EXP;
          resp_d  = {CHAIN_LEN{1'b0}};
          se_d    = 1'b1;
          si_d    = PAT[CHAIN_LEN-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT_IN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          se_d  = 1'b1;
          si_d  = pat_q[CHAIN_LEN-1];
          pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
        end
      end
      ST_CAPTURE: begin
        state_d = ST_SHIFT_OUT;
        se_d    = 1'b1;
      end
      ST_SHIFT_OUT: begin
        resp_d = {resp_q[CHAIN_LEN-2:0], S0};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          se_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign DONE     = done_q;
  assign RESP     = resp_q;
  assign BUSY     = (state_q == ST_SHIFT_IN) || (state_q == ST_CAPTURE) ||
                    (state_q == ST_SHIFT_OUT);
  assign MISMATCH = (resp_q != exp_q);

  scan_popcount #(
    .W  (CHAIN_LEN),
    .CW (CNT_W)
  ) u_popcount (
    .vec_i (resp_q ^ exp_q),
    .cnt_o (ERR_CNT)
  );

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving a 4-cell scan chain model whose
// functional D input is selectable (tied 0, inverted Q, or Q).
module tb_scan_chain_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [N-1:0]  PAT;
  logic [N-1:0]  EXP;
  logic          S0;
  logic          SE;
  logic          SI;
  logic          BUSY;
  logic          DONE;
  logic [N-1:0]  RESP;
  logic          MISMATCH;
  logic [CW-1:0] ERR_CNT;

  logic [N-1:0]  chain_q;
  logic [N-1:0]  chain_d;
  logic [1:0]    dmode;

  int n_checks = 0;
  int n_errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .PAT      (PAT),
    .EXP      (EXP),
    .S0       (S0),
    .SE       (SE),
    .SI       (SI),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESP     (RESP),
    .MISMATCH (MISMATCH),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Functional D input of each scan cell.
  always_comb begin
    case (dmode)
      2'd1:    chain_d = ~chain_q;
      2'd2:    chain_d = chain_q;
      default: chain_d = {N{1'b0}};
    endcase
  end

  // Scan cells: position 0 takes SI, the last position drives S0.
  always @(posedge CLK) begin
    if (SE) chain_q <= {chain_q[N-2:0], SI};
    else    chain_q <= chain_d;
  end

  assign S0 = chain_q[N-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One run from the START edge (edge 0) to DONE (edge 9); mask[k] drives
  // START into edge k for k>=1. PAT/EXP are scrambled once latched.
  task automatic run_check(input logic [N-1:0] pat, input logic [N-1:0] expv,
                           input logic [9:0] mask, input logic [N-1:0] eresp,
                           input logic emis, input logic [CW-1:0] eerr);
    logic [9:0] se_tab;
    logic [9:0] done_tab;
    logic [9:0] busy_tab;
    logic       si_want;
    se_tab   = 10'b0111101111;
    done_tab = 10'b1000000000;
    busy_tab = 10'b0111111111;
    PAT = pat;
    EXP = expv;
    for (int k = 0; k < 10; k++) begin
      START = (k == 0) ? 1'b1 : mask[k];
      tick();
      if (k == 0) begin
        PAT = ~pat;
        EXP = ~expv;
      end
      si_want = (k < N) ? pat[N-1-k] : 1'b0;
      check_eq($sformatf("se_e%0d", k), 32'(SE), 32'(se_tab[k]));
      check_eq($sformatf("si_e%0d", k), 32'(SI), 32'(si_want));
      check_eq($sformatf("done_e%0d", k), 32'(DONE), 32'(done_tab[k]));
      check_eq($sformatf("busy_e%0d", k), 32'(BUSY), 32'(busy_tab[k]));
      if (k == N) check_eq("chain_loaded", 32'(chain_q), 32'(pat));
    end
    START = 1'b0;
    check_eq("resp", 32'(RESP), 32'(eresp));
    check_eq("mismatch", 32'(MISMATCH), 32'(emis));
    check_eq("err_cnt", 32'(ERR_CNT), 32'(eerr));
  endtask

  initial begin
    RST     = 1'b1;
    START   = 1'b0;
    PAT     = 4'b0000;
    EXP     = 4'b0000;
    dmode   = 2'd0;
    chain_q = 4'b0000;
    tick();
    tick();
    check_eq("rst_se", 32'(SE), 32'd0);
    check_eq("rst_si", 32'(SI), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_resp", 32'(RESP), 32'd0);
    check_eq("rst_mis", 32'(MISMATCH), 32'd0);
    check_eq("rst_err", 32'(ERR_CNT), 32'd0);
    RST = 1'b0;
    tick();

    // D tied 0: load order and timing tables, response all zero.
    dmode = 2'd0;
    run_check(4'b1011, 4'b0000, 10'b0, 4'b0000, 1'b0, 3'd0);
    tick();
    check_eq("idle_after_done", 32'(BUSY), 32'd0);

    // D = ~Q: captured value is the inverted pattern.
    dmode = 2'd1;
    run_check(4'b1011, 4'b0100, 10'b0, 4'b0100, 1'b0, 3'd0);
    tick();
    run_check(4'b1011, 4'b0000, 10'b0, 4'b0100, 1'b1, 3'd1);
    tick();

    // D = Q: every bit differs from EXP.
    dmode = 2'd2;
    run_check(4'b0110, 4'b1001, 10'b0, 4'b0110, 1'b1, 3'd4);
    tick();
    check_eq("hold_resp", 32'(RESP), 32'h6);
    check_eq("hold_err", 32'(ERR_CNT), 32'd4);

    // START pulses at cycles 3 and 7 while busy are ignored.
    run_check(4'b0011, 4'b0011, 10'b0010001000, 4'b0011, 1'b0, 3'd0);
    tick();
    check_eq("no_extra_done", 32'(DONE), 32'd0);
    check_eq("no_extra_busy", 32'(BUSY), 32'd0);

    // Back-to-back: START held high through the first DONE.
    run_check(4'b1001, 4'b1001, 10'b1111111110, 4'b1001, 1'b0, 3'd0);
    PAT   = 4'b0110;
    EXP   = 4'b0111;
    START = 1'b1;
    tick();
    check_eq("b2b_busy", 32'(BUSY), 32'd1);
    check_eq("b2b_done", 32'(DONE), 32'd0);
    check_eq("b2b_resp_clr", 32'(RESP), 32'd0);
    check_eq("b2b_se", 32'(SE), 32'd1);
    check_eq("b2b_si", 32'(SI), 32'd0);
    for (int k = 11; k < 20; k++) begin
      tick();
      check_eq($sformatf("b2b_done_e%0d", k), 32'(DONE), 32'((k == 19) ? 1 : 0));
    end
    START = 1'b0;
    check_eq("b2b_resp", 32'(RESP), 32'h6);
    check_eq("b2b_mis", 32'(MISMATCH), 32'd1);
    check_eq("b2b_err", 32'(ERR_CNT), 32'd1);
    tick();

    // Reset mid-run abandons the run without DONE.
    dmode = 2'd0;
    PAT   = 4'b1111;
    EXP   = 4'b1111;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check_eq("pre_rst_mis", 32'(MISMATCH), 32'd1);
    check_eq("pre_rst_err", 32'(ERR_CNT), 32'd4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mid_rst_se", 32'(SE), 32'd0);
    check_eq("mid_rst_si", 32'(SI), 32'd0);
    check_eq("mid_rst_busy", 32'(BUSY), 32'd0);
    check_eq("mid_rst_resp", 32'(RESP), 32'd0);
    check_eq("mid_rst_mis", 32'(MISMATCH), 32'd0);
    check_eq("mid_rst_err", 32'(ERR_CNT), 32'd0);
    for (int k = 6; k < 14; k++) begin
      tick();
      check_eq($sformatf("rst_nodone_e%0d", k), 32'(DONE), 32'd0);
    end
    run_check(4'b1011, 4'b0001, 10'b0, 4'b0000, 1'b1, 3'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
